// File: rtl/arc_pkg.sv
// Shared types for the decode-stage immediate extender.
// Immediate modes and skid buffer occupancy states.
package arc_pkg;

    typedef enum logic [1:0] {
        IMM_ZERO,
        IMM_SIGN,
        IMM_UPPER,
        IMM_BRANCH
    } imm_mode_e;

    typedef enum logic [1:0] {
        SK_EMPTY,
        SK_ONE,
        SK_FULL
    } skid_state_e;

endpackage

// File: rtl/d_imm_ext_unit.sv
// Combinational immediate widener: imm (IN_W) + mode (2) -> ext (OUT_W).
// Modes: zero-extend, sign-extend, upper-load, branch offset (sign << 2).
import arc_pkg::*;

module d_imm_ext_unit #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] ext
);

    logic [OUT_W-1:0] sext;

    assign sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};

    always_comb begin
        ext = '0;
        unique case (imm_mode_e'(mode))
            IMM_ZERO:   ext = {{(OUT_W-IN_W){1'b0}}, imm};
            IMM_SIGN:   ext = sext;
            IMM_UPPER:  ext = {imm, {(OUT_W-IN_W){1'b0}}};
            // top two sign bits fall off the end of the shift
            IMM_BRANCH: ext = {sext[OUT_W-3:0], 2'b00};
        endcase
    end

endmodule

// File: rtl/d_imm_extend_stage.sv
// Decode-stage immediate extender with a 2-entry registered skid output.
// Ports: i_clk, i_rst_n, i_flush, i_valid/o_ready/i_data_immD/i_con_mode in;
//        o_valid/i_ready/o_data_immD/o_con_mode out.
import arc_pkg::*;

module d_imm_extend_stage #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [IN_W-1:0]  i_data_immD,
    input  logic [1:0]       i_con_mode,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [OUT_W-1:0] o_data_immD,
    output logic [1:0]       o_con_mode
);

    if (IN_W < 2 || IN_W > OUT_W - 1 || OUT_W > 64) begin : g_bad_param
        $error("d_imm_extend_stage: illegal IN_W/OUT_W");
    end

    skid_state_e      state_q, state_d;
    logic             rdy_q, rdy_d;
    logic [OUT_W-1:0] m_data_q, m_data_d;
    logic [1:0]       m_mode_q, m_mode_d;
    logic [OUT_W-1:0] s_data_q, s_data_d;
    logic [1:0]       s_mode_q, s_mode_d;
    logic [OUT_W-1:0] ext;
    logic             accept;
    logic             drain;

    d_imm_ext_unit #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_ext (
        .imm  (i_data_immD),
        .mode (i_con_mode),
        .ext  (ext)
    );

    assign accept = i_valid && rdy_q;
    assign drain  = (state_q != SK_EMPTY) && i_ready;

    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        m_mode_d = m_mode_q;
        s_data_d = s_data_q;
        s_mode_d = s_mode_q;
        if (i_flush) begin
            // incoming data is dropped; a same-cycle drain still happened
            state_d = SK_EMPTY;
        end else begin
            unique case (state_q)
                SK_EMPTY: begin
                    if (accept) begin
                        state_d  = SK_ONE;
                        m_data_d = ext;
                        m_mode_d = i_con_mode;
                    end
                end
                SK_ONE: begin
                    if (accept && drain) begin
                        m_data_d = ext;
                        m_mode_d = i_con_mode;
                    end else if (accept) begin
                        state_d  = SK_FULL;
                        s_data_d = ext;
                        s_mode_d = i_con_mode;
                    end else if (drain) begin
                        state_d = SK_EMPTY;
                    end
                end
                SK_FULL: begin
                    if (drain) begin
                        state_d  = SK_ONE;
                        m_data_d = s_data_q;
                        m_mode_d = s_mode_q;
                    end
                end
                default: state_d = SK_EMPTY;
            endcase
        end
        // registered ready: no comb path from i_ready to o_ready
        rdy_d = (state_d != SK_FULL);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= SK_EMPTY;
            rdy_q    <= 1'b0;
            m_data_q <= '0;
            m_mode_q <= '0;
            s_data_q <= '0;
            s_mode_q <= '0;
        end else begin
            state_q  <= state_d;
            rdy_q    <= rdy_d;
            m_data_q <= m_data_d;
            m_mode_q <= m_mode_d;
            s_data_q <= s_data_d;
            s_mode_q <= s_mode_d;
        end
    end

    assign o_valid     = (state_q != SK_EMPTY);
    assign o_ready     = rdy_q;
    assign o_data_immD = m_data_q;
    assign o_con_mode  = m_mode_q;

endmodule

// File: tb/tb_d_imm_extend_stage.sv
// Bench for d_imm_extend_stage (IN_W=16, OUT_W=32): directed steps
// then random traffic against a queue-based reference model.
module tb_d_imm_extend_stage;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [15:0] i_data_immD = '0;
    logic [1:0]  i_con_mode = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_data_immD;
    logic [1:0]  o_con_mode;

    int passes = 0;
    int total  = 0;

    logic [33:0] q[$];
    logic        ready_m = 1'b0;

    always #5 i_clk = ~i_clk;

    d_imm_extend_stage #(
        .IN_W  (16),
        .OUT_W (32)
    ) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_flush     (i_flush),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_data_immD (i_data_immD),
        .i_con_mode  (i_con_mode),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_data_immD (o_data_immD),
        .o_con_mode  (o_con_mode)
    );

    function automatic logic [31:0] ref_ext(input logic [15:0] imm,
                                            input logic [1:0] mode);
        longint s;
        longint u;
        s = longint'($signed(imm));
        u = longint'(imm);
        case (mode)
            2'd0:    return 32'(u);
            2'd1:    return 32'(s);
            2'd2:    return 32'(u * 65536);
            default: return 32'(s * 4);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".valid"}, 64'(o_valid), 64'(q.size() > 0));
        chk({tag, ".ready"}, 64'(o_ready), 64'(ready_m));
        if (q.size() > 0) begin
            chk({tag, ".data"}, 64'(o_data_immD), 64'(q[0][31:0]));
            chk({tag, ".mode"}, 64'(o_con_mode), 64'(q[0][33:32]));
        end
    endtask

    // Drive one cycle of inputs, clock it, advance model, check.
    task automatic tick(input string tag, input logic v,
                        input logic [15:0] imm, input logic [1:0] mode,
                        input logic rdy, input logic fl);
        logic        acc;
        logic        drn;
        logic        stall;
        logic [33:0] held;
        i_valid     = v;
        i_data_immD = imm;
        i_con_mode  = mode;
        i_ready     = rdy;
        i_flush     = fl;
        acc   = v && ready_m;
        drn   = (q.size() > 0) && rdy;
        stall = o_valid && !rdy && !fl;
        held  = {o_con_mode, o_data_immD};
        @(posedge i_clk);
        #1;
        if (drn) void'(q.pop_front());
        if (fl) q.delete();
        else if (acc) q.push_back({mode, ref_ext(imm, mode)});
        ready_m = fl || (q.size() != 2);
        chk_model(tag);
        if (stall)
            chk({tag, ".stable"}, 64'({o_con_mode, o_data_immD}), 64'(held));
    endtask

    initial begin
        // reset state
        #2;
        chk("rst.valid", 64'(o_valid), 64'd0);
        chk("rst.ready", 64'(o_ready), 64'd0);
        chk("rst.data", 64'(o_data_immD), 64'd0);
        chk("rst.mode", 64'(o_con_mode), 64'd0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        tick("rel", 0, 16'h0, 2'd0, 1, 0);
        chk("rel.ready_up", 64'(o_ready), 64'd1);

        // 1: sign extend, one-cycle latency
        tick("t1", 1, 16'h8001, 2'd1, 1, 0);
        chk("t1.val", 64'(o_data_immD), 64'hFFFF8001);
        chk("t1.vld", 64'(o_valid), 64'd1);

        // 2: mode sweep
        tick("t2z", 1, 16'h8001, 2'd0, 1, 0);
        chk("t2.zero", 64'(o_data_immD), 64'h00008001);
        tick("t2u", 1, 16'h1234, 2'd2, 1, 0);
        chk("t2.upper", 64'(o_data_immD), 64'h12340000);
        tick("t2b", 1, 16'hFFFF, 2'd3, 1, 0);
        chk("t2.branch", 64'(o_data_immD), 64'hFFFFFFFC);
        tick("t2e", 0, 16'h0, 2'd0, 1, 0);
        chk("t2.empty", 64'(o_valid), 64'd0);

        // 3: A,B,C with stalled output
        tick("t3a", 1, 16'h000A, 2'd0, 0, 0);
        tick("t3b", 1, 16'h000B, 2'd0, 0, 0);
        chk("t3.notready", 64'(o_ready), 64'd0);
        chk("t3.holdA", 64'(o_data_immD), 64'h0000000A);
        tick("t3c0", 1, 16'h000C, 2'd0, 0, 0);
        chk("t3.stillA", 64'(o_data_immD), 64'h0000000A);
        tick("t3c1", 1, 16'h000C, 2'd0, 1, 0);
        chk("t3.outB", 64'(o_data_immD), 64'h0000000B);
        tick("t3c2", 1, 16'h000C, 2'd0, 1, 0);
        chk("t3.outC", 64'(o_data_immD), 64'h0000000C);
        tick("t3d", 0, 16'h0, 2'd0, 1, 0);
        chk("t3.drained", 64'(o_valid), 64'd0);

        // 4: flush from FULL with a same-cycle valid input
        tick("t4a", 1, 16'h0111, 2'd1, 0, 0);
        tick("t4b", 1, 16'h0222, 2'd1, 0, 0);
        tick("t4f", 1, 16'h0DEA, 2'd2, 0, 1);
        chk("t4.valid0", 64'(o_valid), 64'd0);
        chk("t4.ready1", 64'(o_ready), 64'd1);
        tick("t4n", 0, 16'h0, 2'd0, 1, 0);
        chk("t4.noghost", 64'(o_valid), 64'd0);

        // 5: asynchronous reset between edges
        tick("t5a", 1, 16'h4321, 2'd1, 0, 0);
        #2;
        i_rst_n = 1'b0;
        #1;
        chk("t5.valid0", 64'(o_valid), 64'd0);
        chk("t5.data0", 64'(o_data_immD), 64'd0);
        chk("t5.ready0", 64'(o_ready), 64'd0);
        q.delete();
        ready_m = 1'b0;
        i_valid = 1'b0;
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;
        tick("t5r", 0, 16'h0, 2'd0, 1, 0);
        tick("t5x", 1, 16'h7FFF, 2'd3, 1, 0);
        chk("t5.first", 64'(o_data_immD), 64'h0001FFFC);

        // 6: random traffic
        for (int n = 0; n < 10000; n++) begin
            tick("rnd", 1'($urandom), 16'($urandom), 2'($urandom),
                 1'($urandom), $urandom_range(0, 63) == 0);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
